// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory responder for the MEM stage.
// Each load/store is answered after WAIT_STATES extra busy cycles.
// The pipeline is held through `stall` until the access completes.
// Optional feature: define MEM_RESP_ADDR_CHECK_EN to flag misaligned or
// out-of-range addresses. Flagged accesses suppress the write, return 0 on a
// read, and pulse addr_err together with done.
module data_mem_responder #(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        addr_err
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   op_wr_q;
   logic [ADDR_BITS-1:0]   idx_q;
   logic [31:0]            wdata_q;
   logic                   err_q;
   logic [31:0]            rdata_q;
   logic                   done_q;
   logic                   addr_err_q;
   logic [31:0]            mem_q [DEPTH];

   logic                   req_any_s;
   logic                   access_s;
   logic                   addr_ill_s;

   assign req_any_s = req_read | req_write;
   // The access itself happens on the last BUSY edge.
   assign access_s  = (state_q == ST_BUSY) && (cnt_q == 4'd0);

`ifdef MEM_RESP_ADDR_CHECK_EN
   assign addr_ill_s = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_BITS+2]);
   assign addr_err   = addr_err_q;
`else
   // Without the check, the low and high address bits are simply dropped.
   logic unused_addr_s;
   logic unused_err_s;
   assign unused_addr_s = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};
   assign unused_err_s  = addr_err_q;
   assign addr_ill_s    = 1'b0;
   assign addr_err      = 1'b0;
`endif

   // Next-state and wait-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_any_s) begin
               state_d = ST_BUSY;
               cnt_d   = 4'(WAIT_STATES);
            end else begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               state_d = ST_BUSY;
               cnt_d   = cnt_q - 4'd1;
            end else begin
               state_d = ST_DONE;
               cnt_d   = cnt_q;
            end
         end
         ST_DONE: begin
            // Request lines still belong to the completed access here.
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // FSM state, request latches and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         op_wr_q    <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 32'd0;
         err_q      <= 1'b0;
         rdata_q    <= 32'd0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == ST_IDLE) && req_any_s) begin
            // A simultaneous read and write is handled as a write.
            op_wr_q <= req_write;
            idx_q   <= req_addr[ADDR_BITS+1:2];
            wdata_q <= req_wdata;
            err_q   <= addr_ill_s;
         end
         if (access_s && !op_wr_q) begin
            rdata_q <= err_q ? 32'd0 : mem_q[idx_q];
         end
         done_q     <= access_s;
         addr_err_q <= access_s & err_q;
      end
   end

   // Memory array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (access_s && op_wr_q && !err_q && rst) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign rdata = rdata_q;
   assign done  = done_q;
   // Gated by rst so stall drops the moment reset is asserted.
   assign stall = rst & (((state_q == ST_IDLE) & req_any_s) | (state_q == ST_BUSY));

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized load/store traffic checked against a transaction-level model.
module tb_data_mem_responder;

   localparam int AB = 8;
   localparam int WS = 2;

   logic        clk;
   logic        rst;
   logic        req_read;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        done;
   logic        addr_err;

   int n_checks;
   int n_pass;

   // Reference model state
   logic [31:0] mdl_mem [0:(1<<AB)-1];
   logic [31:0] mdl_rdata;

   data_mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_read  (req_read),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rdata     (rdata),
      .stall     (stall),
      .done      (done),
      .addr_err  (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic is_illegal(input logic [31:0] a);
`ifdef MEM_RESP_ADDR_CHECK_EN
      return (a[1:0] != 2'b00) || ((a >> (AB + 2)) != 32'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % (1 << AB));
   endfunction

   // One complete access. Starts at the next falling edge and returns at the
   // falling edge of the done cycle, with the request still held.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input string tag);
      int    lat;
      int    stalls;
      logic  ill;
      logic  got_done;
      @(negedge clk);
      req_read  = rd;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      check_eq({tag, ".stall0"}, {31'd0, stall}, 32'd1);
      check_eq({tag, ".done0"},  {31'd0, done},  32'd0);
      ill      = is_illegal(addr);
      lat      = 0;
      stalls   = 1;
      got_done = 1'b0;
      while (lat < 40 && !got_done) begin
         @(negedge clk);
         lat++;
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (stall) stalls++;
            // Request lines wander during BUSY; the latched copy must be used.
            req_addr  = $urandom;
            req_wdata = $urandom;
         end
      end
      check_eq({tag, ".latency"}, lat, WS + 2);
      check_eq({tag, ".stalls"}, stalls, WS + 2);
      check_eq({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
      // Model update: a completed access at the transaction level.
      if (wr) begin
         if (!ill) mdl_mem[word_of(addr)] = wd;
      end else if (rd) begin
         mdl_rdata = ill ? 32'd0 : mdl_mem[word_of(addr)];
      end
      check_eq({tag, ".rdata"}, rdata, mdl_rdata);
      check_eq({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, ill});
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         req_read  = 1'b0;
         req_write = 1'b0;
         #1;
         check_eq("idle.stall", {31'd0, stall}, 32'd0);
         check_eq("idle.done",  {31'd0, done},  32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] saved;
      int          op;
      int          w;
      logic [31:0] a;
      n_checks  = 0;
      n_pass    = 0;
      mdl_rdata = 32'd0;
      rst       = 1'b0;
      req_read  = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Reset state with no traffic for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("rst.stall", {31'd0, stall}, 32'd0);
         check_eq("rst.done",  {31'd0, done},  32'd0);
         check_eq("rst.rdata", rdata, 32'd0);
         check_eq("rst.aerr",  {31'd0, addr_err}, 32'd0);
      end

      // Known contents for words 0..15.
      for (int k = 0; k < 16; k++) begin
         do_access(1'b0, 1'b1, 32'(k * 4), $urandom, "fill");
      end

      // Write then read 0x10.
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
      do_access(1'b1, 1'b0, 32'h10, 32'd0, "rd10");
      check_eq("rd10.val", rdata, 32'hDEADBEEF);

      // Back-to-back writes and reads with no gap beyond the IDLE cycle.
      do_access(1'b0, 1'b1, 32'h0, 32'h11111111, "b2b_w0");
      do_access(1'b0, 1'b1, 32'h4, 32'h22222222, "b2b_w4");
      do_access(1'b1, 1'b0, 32'h0, 32'd0, "b2b_r0");
      do_access(1'b1, 1'b0, 32'h4, 32'd0, "b2b_r4");
      check_eq("b2b_r4.val", rdata, 32'h22222222);

      // Reset during BUSY aborts the pending write.
      do_access(1'b0, 1'b1, 32'h20, 32'hCAFE0020, "pre20");
      @(negedge clk);
      req_read  = 1'b0;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h1;
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_eq("abort.stall", {31'd0, stall}, 32'd0);
      check_eq("abort.done",  {31'd0, done},  32'd0);
      check_eq("abort.rdata", rdata, 32'd0);
      check_eq("abort.aerr",  {31'd0, addr_err}, 32'd0);
      mdl_rdata = 32'd0;
      req_write = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(2);
      do_access(1'b1, 1'b0, 32'h20, 32'd0, "post20");
      check_eq("post20.val", rdata, 32'hCAFE0020);

      // Misaligned and out-of-range addresses, then read word 0.
      do_access(1'b0, 1'b1, 32'h0, 32'h0BADF00D, "w0");
      do_access(1'b0, 1'b1, 32'h402, 32'h12345678, "w402");
      do_access(1'b0, 1'b1, 32'h400, 32'h87654321, "w400");
      do_access(1'b1, 1'b0, 32'h0, 32'd0, "r0");

      // Combined read+write is a write; rdata must not move.
      saved = rdata;
      do_access(1'b1, 1'b1, 32'h8, 32'h55, "rw8");
      check_eq("rw8.hold", rdata, saved);
      do_access(1'b1, 1'b0, 32'h8, 32'd0, "r8");
      check_eq("r8.val", rdata, 32'h55);

      // Randomized traffic over words 0..15 with aliased and misaligned addresses.
      for (int t = 0; t < 60; t++) begin
         op = int'($urandom_range(0, 3));
         w  = int'($urandom_range(0, 15));
         a  = 32'(w * 4);
         if ($urandom_range(0, 3) == 0) a = a + ($urandom_range(1, 7) << (AB + 2));
         if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
         case (op)
            0:       do_access(1'b1, 1'b0, a, $urandom, "rnd_rd");
            1:       do_access(1'b0, 1'b1, a, $urandom, "rnd_wr");
            2:       do_access(1'b1, 1'b1, a, $urandom, "rnd_rw");
            default: do_access(1'b1, 1'b0, a, $urandom, "rnd_rd2");
         endcase
         if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
      end

      idle_cycles(1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
